// File: rtl/sdram_rd_burst_ctrl.sv
// sdram_rd_burst_ctrl
//   Read-burst engine between the SDRAM arbiter and the command/DQ mux.
//   Accepts one {bank,row,col} + length request and issues
//   ACTIVE / READ / BURST_TERMINATE / PRECHARGE per row segment. Requests
//   that run past the end of a page are split into one segment per row,
//   with the row carrying into the bank and the bank wrapping to zero.
//
// Ports
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   init_end             SDRAM init complete; requests ignored while low
//   rd_req               request from the arbiter, held until rd_ack
//   rd_addr, rd_len      start address {bank,row,col} and word count
//   rd_sdram_data        SDRAM DQ input
//   rd_ack               one-cycle pulse when the request is latched
//   rd_busy              high from the ack cycle through the done cycle
//   rd_done              one-cycle pulse once all words are returned
//   rd_data_valid/out    returned words, in ascending address order
//   rd_sdram_cmd         {cs_n,ras_n,cas_n,we_n}
//   rd_sdram_addr/bank   SDRAM address and bank buses
module sdram_rd_burst_ctrl #(
  parameter int DQ_W   = 16,
  parameter int COL_W  = 9,
  parameter int ROW_W  = 12,
  parameter int BANK_W = 2,
  parameter int LEN_W  = 10,
  parameter int CL     = 3,
  parameter int TRCD   = 3,
  parameter int TRP    = 2
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  input  logic                            init_end,
  input  logic                            rd_req,
  input  logic [BANK_W+ROW_W+COL_W-1:0]   rd_addr,
  input  logic [LEN_W-1:0]                rd_len,
  input  logic [DQ_W-1:0]                 rd_sdram_data,
  output logic                            rd_ack,
  output logic                            rd_busy,
  output logic                            rd_done,
  output logic                            rd_data_valid,
  output logic [DQ_W-1:0]                 rd_data_out,
  output logic [3:0]                      rd_sdram_cmd,
  output logic [ROW_W-1:0]                rd_sdram_addr,
  output logic [BANK_W-1:0]               rd_sdram_bank
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_READ = 4'b0101;
  localparam logic [3:0] CMD_BST  = 4'b0110;
  localparam logic [3:0] CMD_PRE  = 4'b0010;

  localparam int AW = BANK_W + ROW_W + COL_W;
  localparam int PW = BANK_W + ROW_W;
  localparam int SW = (LEN_W > COL_W + 1) ? LEN_W : COL_W + 1;

  typedef enum logic [3:0] {
    IDLE, ACT, TRCD_W, RD, BURST, DRAIN, PRE, TRP_W, DONE
  } state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      page_r, page_nxt;
  logic [COL_W-1:0]   col_r, col_nxt;
  logic [SW-1:0]      rem_r, rem_nxt;
  logic [SW-1:0]      cnt_r, cnt_nxt;
  logic [SW-1:0]      page_left, seg;
  logic               win_r, win_nxt;
  logic [CL-1:0]      win_d;
  logic               accept, seg_end;
  logic               ack_nxt, busy_nxt, done_nxt;
  logic [3:0]         cmd_nxt;
  logic [ROW_W-1:0]   addr_nxt;
  logic [BANK_W-1:0]  bank_nxt;

  assign accept    = rd_req && init_end;
  assign page_left = (SW'(1) << COL_W) - SW'(col_r);
  assign seg       = (rem_r < page_left) ? rem_r : page_left;

  // Next state plus the registered values of every output for the next
  // cycle. The state register holds the phase whose command is currently
  // on the bus, so outputs are decoded from state_nxt.
  always_comb begin
    state_nxt = state;
    page_nxt  = page_r;
    col_nxt   = col_r;
    rem_nxt   = rem_r;
    cnt_nxt   = cnt_r;
    ack_nxt   = 1'b0;
    seg_end   = 1'b0;

    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (accept) begin
          ack_nxt  = 1'b1;
          page_nxt = rd_addr[AW-1:COL_W];
          col_nxt  = rd_addr[COL_W-1:0];
          rem_nxt  = SW'(rd_len);
          // A zero-length request parks one silent cycle in TRP_W so that
          // rd_done follows the ack by exactly one cycle.
          if (rd_len == '0) begin
            state_nxt = TRP_W;
            cnt_nxt   = '0;
          end else begin
            state_nxt = ACT;
          end
        end
      end
      ACT: begin
        if (TRCD == 1) begin
          state_nxt = RD;
        end else begin
          state_nxt = TRCD_W;
          cnt_nxt   = SW'(TRCD - 2);
        end
      end
      TRCD_W: begin
        if (cnt_r == '0) state_nxt = RD;
        else             cnt_nxt   = cnt_r - SW'(1);
      end
      // BURST spans the seg cycles after READ; its last cycle carries BST.
      RD: begin
        state_nxt = BURST;
        cnt_nxt   = seg - SW'(1);
        rem_nxt   = rem_r - seg;
      end
      BURST: begin
        if (cnt_r == '0) begin
          state_nxt = DRAIN;
          cnt_nxt   = SW'(CL - 2);
        end else begin
          cnt_nxt = cnt_r - SW'(1);
        end
      end
      DRAIN: begin
        if (cnt_r == '0) state_nxt = PRE;
        else             cnt_nxt   = cnt_r - SW'(1);
      end
      PRE: begin
        if (TRP == 1) begin
          seg_end = 1'b1;
        end else begin
          state_nxt = TRP_W;
          cnt_nxt   = SW'(TRP - 2);
        end
      end
      TRP_W: begin
        if (cnt_r == '0) seg_end = 1'b1;
        else             cnt_nxt = cnt_r - SW'(1);
      end
      default: state_nxt = IDLE;
    endcase

    // Next segment starts at column 0 of the following row; incrementing
    // the combined {bank,row} gives the row-to-bank carry and bank wrap.
    if (seg_end) begin
      if (rem_r != '0) begin
        state_nxt = ACT;
        page_nxt  = page_r + PW'(1);
        col_nxt   = '0;
      end else begin
        state_nxt = DONE;
      end
    end

    cmd_nxt  = CMD_NOP;
    addr_nxt = '1;
    bank_nxt = '1;
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
    win_nxt  = 1'b0;

    // win marks the cycles in which a column is being read (READ up to the
    // cycle before BST); delayed by CL it becomes the DQ capture strobe.
    case (state_nxt)
      ACT: begin
        cmd_nxt  = CMD_ACT;
        addr_nxt = page_nxt[ROW_W-1:0];
        bank_nxt = page_nxt[PW-1:ROW_W];
      end
      RD: begin
        cmd_nxt  = CMD_READ;
        addr_nxt = ROW_W'(col_nxt);
        bank_nxt = page_nxt[PW-1:ROW_W];
        win_nxt  = 1'b1;
      end
      BURST: begin
        if (cnt_nxt == '0) cmd_nxt = CMD_BST;
        else               win_nxt = 1'b1;
      end
      PRE: begin
        cmd_nxt  = CMD_PRE;
        bank_nxt = page_nxt[PW-1:ROW_W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      page_r        <= '0;
      col_r         <= '0;
      rem_r         <= '0;
      cnt_r         <= '0;
      win_r         <= 1'b0;
      rd_ack        <= 1'b0;
      rd_busy       <= 1'b0;
      rd_done       <= 1'b0;
      rd_sdram_cmd  <= CMD_NOP;
      rd_sdram_addr <= '1;
      rd_sdram_bank <= '1;
    end else begin
      state         <= state_nxt;
      page_r        <= page_nxt;
      col_r         <= col_nxt;
      rem_r         <= rem_nxt;
      cnt_r         <= cnt_nxt;
      win_r         <= win_nxt;
      rd_ack        <= ack_nxt;
      rd_busy       <= busy_nxt;
      rd_done       <= done_nxt;
      rd_sdram_cmd  <= cmd_nxt;
      rd_sdram_addr <= addr_nxt;
      rd_sdram_bank <= bank_nxt;
    end
  end

  // Word k of a segment is on DQ in cycle READ+CL+k; capture it at the end
  // of that cycle so rd_data_valid appears one cycle later, gap-free.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      win_d         <= '0;
      rd_data_valid <= 1'b0;
      rd_data_out   <= '0;
    end else begin
      win_d         <= {win_d[CL-2:0], win_r};
      rd_data_valid <= win_d[CL-1];
      if (win_d[CL-1]) rd_data_out <= rd_sdram_data;
    end
  end

endmodule

// File: tb/tb_sdram_rd_burst_ctrl.sv
// tb_sdram_rd_burst_ctrl
//   Self-checking bench. A small SDRAM model answers the DUT's commands on
//   DQ; every request pushes its expected words to a scoreboard queue that
//   is drained whenever rd_data_valid is seen. Per-scenario tasks check
//   command timing and counts against values derived from the parameters.
`timescale 1ns/1ps
module tb_sdram_rd_burst_ctrl;

  localparam int DQ_W = 16, COL_W = 9, ROW_W = 12, BANK_W = 2, LEN_W = 10;
  localparam int CL = 3, TRCD = 3, TRP = 2;
  localparam int AW = BANK_W + ROW_W + COL_W;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_READ = 4'b0101;
  localparam logic [3:0] C_BST = 4'b0110, C_PRE = 4'b0010;
  localparam logic [DQ_W-1:0] JUNK = 16'hDEAD;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n, init_end, rd_req;
  logic [AW-1:0]     rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic [DQ_W-1:0]   rd_sdram_data;
  logic              rd_ack, rd_busy, rd_done, rd_data_valid;
  logic [DQ_W-1:0]   rd_data_out;
  logic [3:0]        rd_sdram_cmd;
  logic [ROW_W-1:0]  rd_sdram_addr;
  logic [BANK_W-1:0] rd_sdram_bank;

  sdram_rd_burst_ctrl #(
    .DQ_W(DQ_W), .COL_W(COL_W), .ROW_W(ROW_W), .BANK_W(BANK_W),
    .LEN_W(LEN_W), .CL(CL), .TRCD(TRCD), .TRP(TRP)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_sdram_data(rd_sdram_data), .rd_ack(rd_ack), .rd_busy(rd_busy),
    .rd_done(rd_done), .rd_data_valid(rd_data_valid),
    .rd_data_out(rd_data_out), .rd_sdram_cmd(rd_sdram_cmd),
    .rd_sdram_addr(rd_sdram_addr), .rd_sdram_bank(rd_sdram_bank)
  );

  initial forever #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int vec_cnt = 0, err_cnt = 0;
  logic [DQ_W-1:0] exp_q[$];

  typedef struct {int due; logic [DQ_W-1:0] data;} pend_t;
  pend_t pend_q[$];
  logic [ROW_W-1:0]  open_row [0:3];
  logic              bursting;
  logic [BANK_W-1:0] b_bank;
  logic [ROW_W-1:0]  b_row;
  logic [COL_W-1:0]  b_col;

  int ack_n, ack_cyc, done_n, done_cyc, busy_n, val_n, val_first, val_last;
  int act_n, act_first_cyc, rd_n, rd_first_cyc, bst_n, bst_first_cyc;
  int pre_n, pre_first_cyc, cmd_other, idle_bad;
  logic [ROW_W-1:0]  act_first_row, act_last_row, rd_first_addr, rd_last_addr, pre_first_addr;
  logic [BANK_W-1:0] act_first_bank, act_last_bank;

  function automatic logic [DQ_W-1:0] word_of(input logic [AW-1:0] a);
    logic [31:0] x;
    x = {9'd0, a} * 32'd40503 + 32'h1234;
    return x[23:8];
  endfunction

  // SDRAM model, event log and scoreboard, all sampled mid-cycle.
  initial begin
    pend_t p;
    logic [DQ_W-1:0] e;
    bursting = 1'b0;
    rd_sdram_data = JUNK;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        bursting = 1'b0;
        pend_q.delete();
        rd_sdram_data = JUNK;
      end else begin
        rd_sdram_data = JUNK;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
          p = pend_q.pop_front();
          rd_sdram_data = p.data;
        end
        case (rd_sdram_cmd)
          C_ACT: begin
            open_row[rd_sdram_bank] = rd_sdram_addr;
            if (act_n == 0) begin
              act_first_cyc = cyc; act_first_row = rd_sdram_addr; act_first_bank = rd_sdram_bank;
            end
            act_last_row = rd_sdram_addr; act_last_bank = rd_sdram_bank;
            act_n++; cmd_other++;
          end
          C_READ: begin
            bursting = 1'b1; b_bank = rd_sdram_bank; b_row = open_row[rd_sdram_bank];
            b_col = rd_sdram_addr[COL_W-1:0];
            if (rd_n == 0) begin rd_first_cyc = cyc; rd_first_addr = rd_sdram_addr; end
            rd_last_addr = rd_sdram_addr;
            rd_n++; cmd_other++;
          end
          C_BST: begin
            bursting = 1'b0;
            if (bst_n == 0) bst_first_cyc = cyc;
            bst_n++; cmd_other++;
          end
          C_PRE: begin
            bursting = 1'b0;
            if (pre_n == 0) begin pre_first_cyc = cyc; pre_first_addr = rd_sdram_addr; end
            pre_n++; cmd_other++;
          end
          C_NOP: if (rd_sdram_addr !== '1 || rd_sdram_bank !== '1) idle_bad++;
          default: cmd_other++;
        endcase
        if (bursting) begin
          p.due = cyc + CL;
          p.data = word_of({b_bank, b_row, b_col});
          pend_q.push_back(p);
          b_col = b_col + 1'b1;
        end
      end
      if (rd_ack) begin ack_n++; ack_cyc = cyc; end
      if (rd_done) begin done_n++; done_cyc = cyc; end
      if (rd_busy) busy_n++;
      if (rd_data_valid) begin
        if (val_n == 0) val_first = cyc;
        val_last = cyc;
        val_n++;
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("[TB] FAIL sb_unexpected: got word %h at cycle %0d, expected no word", rd_data_out, cyc);
        end else begin
          e = exp_q.pop_front();
          if (rd_data_out !== e) begin
            err_cnt++;
            $display("[TB] FAIL sb_data: got %h, expected %h at cycle %0d", rd_data_out, e, cyc);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic clear_log();
    ack_n = 0; ack_cyc = 0; done_n = 0; done_cyc = 0; busy_n = 0;
    val_n = 0; val_first = 0; val_last = 0; act_n = 0; act_first_cyc = 0;
    rd_n = 0; rd_first_cyc = 0; bst_n = 0; bst_first_cyc = 0;
    pre_n = 0; pre_first_cyc = 0; cmd_other = 0; idle_bad = 0;
  endtask

  task automatic issue(input logic [AW-1:0] addr, input logic [LEN_W-1:0] len);
    int n;
    for (int i = 0; i < int'(len); i++) exp_q.push_back(word_of(AW'(addr + AW'(i))));
    rd_addr = addr; rd_len = len; rd_req = 1'b1;
    n = 0;
    while (ack_n == 0 && n < 20) begin step(); n++; end
    rd_req = 1'b0;
    vec_cnt++;
    if (ack_n != 1) begin err_cnt++; $display("[TB] FAIL ack_seen: got %0d acks, expected 1", ack_n); end
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (done_n == 0 && n < bound) begin step(); n++; end
    vec_cnt++;
    if (done_n == 0) begin err_cnt++; $display("[TB] FAIL done_timeout: got no rd_done in %0d cycles, expected one", bound); end
    step(); step();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; init_end = 1'b0; rd_req = 1'b0; rd_addr = '0; rd_len = '0;
    clear_log();
    step(); step();
    vec_cnt++; if (rd_sdram_cmd !== C_NOP) begin err_cnt++; $display("[TB] FAIL rst_cmd: got %h, expected %h", rd_sdram_cmd, C_NOP); end
    vec_cnt++; if (rd_sdram_addr !== 12'hFFF) begin err_cnt++; $display("[TB] FAIL rst_addr: got %h, expected fff", rd_sdram_addr); end
    vec_cnt++; if (rd_sdram_bank !== 2'b11) begin err_cnt++; $display("[TB] FAIL rst_bank: got %h, expected 3", rd_sdram_bank); end
    vec_cnt++; if ({rd_ack, rd_busy, rd_done, rd_data_valid} !== 4'b0) begin err_cnt++; $display("[TB] FAIL rst_flags: got %b, expected 0000", {rd_ack, rd_busy, rd_done, rd_data_valid}); end
    vec_cnt++; if (rd_data_out !== '0) begin err_cnt++; $display("[TB] FAIL rst_data: got %h, expected 0", rd_data_out); end
    sys_rst_n = 1'b1;
    step();
    init_end = 1'b1;
    step();
  endtask

  task automatic test_basic_timing();
    int a;
    clear_log();
    issue({2'd0, 12'd5, 9'd0}, 10'd4);
    wait_done(100);
    a = ack_cyc;
    vec_cnt++; if (act_first_cyc != a) begin err_cnt++; $display("[TB] FAIL t1_act_cyc: got %0d, expected %0d", act_first_cyc, a); end
    vec_cnt++; if (act_first_row !== 12'd5 || act_first_bank !== 2'd0) begin err_cnt++; $display("[TB] FAIL t1_act_addr: got b%0d r%0d, expected b0 r5", act_first_bank, act_first_row); end
    vec_cnt++; if (rd_first_cyc != a + TRCD || rd_first_addr !== 12'd0) begin err_cnt++; $display("[TB] FAIL t1_read: got cyc %0d col %0d, expected cyc %0d col 0", rd_first_cyc, rd_first_addr, a + TRCD); end
    vec_cnt++; if (bst_first_cyc != a + TRCD + 4) begin err_cnt++; $display("[TB] FAIL t1_bst_cyc: got %0d, expected %0d", bst_first_cyc, a + TRCD + 4); end
    vec_cnt++; if (val_first != a + TRCD + CL + 1 || val_last != a + TRCD + CL + 4 || val_n != 4) begin err_cnt++; $display("[TB] FAIL t1_valid: got %0d..%0d n=%0d, expected %0d..%0d n=4", val_first, val_last, val_n, a + TRCD + CL + 1, a + TRCD + CL + 4); end
    vec_cnt++; if (pre_first_cyc != a + TRCD + CL + 4 || pre_first_addr !== 12'hFFF) begin err_cnt++; $display("[TB] FAIL t1_pre: got cyc %0d addr %h, expected cyc %0d addr fff", pre_first_cyc, pre_first_addr, a + TRCD + CL + 4); end
    vec_cnt++; if (done_cyc != a + TRCD + CL + 4 + TRP || done_n != 1) begin err_cnt++; $display("[TB] FAIL t1_done: got cyc %0d n=%0d, expected cyc %0d n=1", done_cyc, done_n, a + TRCD + CL + 4 + TRP); end
    vec_cnt++; if (busy_n != TRCD + CL + 4 + TRP + 1) begin err_cnt++; $display("[TB] FAIL t1_busy_len: got %0d, expected %0d", busy_n, TRCD + CL + 4 + TRP + 1); end
    vec_cnt++; if (idle_bad != 0) begin err_cnt++; $display("[TB] FAIL t1_idle_bus: got %0d bad NOP cycles, expected 0", idle_bad); end
  endtask

  task automatic test_page_cross();
    clear_log();
    issue({2'd0, 12'd5, 9'd510}, 10'd4);
    wait_done(100);
    vec_cnt++; if (act_n != 2 || pre_n != 2 || rd_n != 2) begin err_cnt++; $display("[TB] FAIL pc_counts: got act %0d pre %0d rd %0d, expected 2 2 2", act_n, pre_n, rd_n); end
    vec_cnt++; if (rd_first_addr !== 12'd510 || rd_last_addr !== 12'd0) begin err_cnt++; $display("[TB] FAIL pc_cols: got %0d then %0d, expected 510 then 0", rd_first_addr, rd_last_addr); end
    vec_cnt++; if (act_last_row !== 12'd6) begin err_cnt++; $display("[TB] FAIL pc_row: got %0d, expected 6", act_last_row); end
    vec_cnt++; if (val_n != 4 || done_n != 1) begin err_cnt++; $display("[TB] FAIL pc_words: got %0d words %0d dones, expected 4 and 1", val_n, done_n); end
  endtask

  task automatic test_row_bank_carry();
    clear_log();
    issue({2'd0, 12'hFFF, 9'd511}, 10'd2);
    wait_done(100);
    vec_cnt++; if (act_n != 2 || act_last_bank !== 2'd1 || act_last_row !== 12'd0) begin err_cnt++; $display("[TB] FAIL carry_bank: got n=%0d b%0d r%0d, expected n=2 b1 r0", act_n, act_last_bank, act_last_row); end
    clear_log();
    issue(23'h7FFFFF, 10'd2);
    wait_done(100);
    vec_cnt++; if (act_first_bank !== 2'd3 || act_first_row !== 12'hFFF) begin err_cnt++; $display("[TB] FAIL wrap_first: got b%0d r%h, expected b3 rfff", act_first_bank, act_first_row); end
    vec_cnt++; if (act_last_bank !== 2'd0 || act_last_row !== 12'd0 || val_n != 2) begin err_cnt++; $display("[TB] FAIL wrap_second: got b%0d r%h words %0d, expected b0 r0 words 2", act_last_bank, act_last_row, val_n); end
  endtask

  task automatic test_full_page();
    clear_log();
    issue({2'd2, 12'd77, 9'd0}, 10'd512);
    wait_done(2000);
    vec_cnt++; if (val_n != 512 || val_last - val_first != 511) begin err_cnt++; $display("[TB] FAIL fp_valid: got n=%0d span %0d, expected 512 span 511", val_n, val_last - val_first); end
    vec_cnt++; if (bst_first_cyc != rd_first_cyc + 512) begin err_cnt++; $display("[TB] FAIL fp_bst: got %0d, expected %0d", bst_first_cyc, rd_first_cyc + 512); end
    vec_cnt++; if (act_n != 1 || pre_n != 1) begin err_cnt++; $display("[TB] FAIL fp_segments: got act %0d pre %0d, expected 1 1", act_n, pre_n); end
  endtask

  task automatic test_zero_len();
    clear_log();
    issue({2'd1, 12'd9, 9'd3}, 10'd0);
    wait_done(20);
    vec_cnt++; if (done_cyc != ack_cyc + 1 || done_n != 1) begin err_cnt++; $display("[TB] FAIL zl_done: got cyc %0d n=%0d, expected cyc %0d n=1", done_cyc, done_n, ack_cyc + 1); end
    vec_cnt++; if (cmd_other != 0 || val_n != 0) begin err_cnt++; $display("[TB] FAIL zl_silent: got %0d cmds %0d words, expected 0 0", cmd_other, val_n); end
    vec_cnt++; if (busy_n != 2) begin err_cnt++; $display("[TB] FAIL zl_busy: got %0d, expected 2", busy_n); end
  endtask

  task automatic test_no_init();
    clear_log();
    init_end = 1'b0;
    rd_addr = {2'd1, 12'd1, 9'd1}; rd_len = 10'd3; rd_req = 1'b1;
    for (int i = 0; i < 10; i++) step();
    rd_req = 1'b0;
    init_end = 1'b1;
    step();
    vec_cnt++; if (ack_n != 0 || busy_n != 0 || cmd_other != 0) begin err_cnt++; $display("[TB] FAIL noinit: got ack %0d busy %0d cmds %0d, expected 0 0 0", ack_n, busy_n, cmd_other); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    issue({2'd3, 12'd200, 9'd10}, 10'd8);
    for (int i = 0; i < 3; i++) step();
    init_end = 1'b0;
    rd_addr = {2'd0, 12'd1, 9'd0}; rd_len = 10'd5; rd_req = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rd_req = 1'b0;
    wait_done(100);
    init_end = 1'b1;
    vec_cnt++; if (ack_n != 1 || done_n != 1) begin err_cnt++; $display("[TB] FAIL busy_ignore: got ack %0d done %0d, expected 1 1", ack_n, done_n); end
    vec_cnt++; if (val_n != 8) begin err_cnt++; $display("[TB] FAIL busy_words: got %0d, expected 8", val_n); end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    clear_log();
    issue({2'd1, 12'h040, 9'd0}, 10'd16);
    n = 0;
    while (val_n < 3 && n < 100) begin step(); n++; end
    vec_cnt++; if (val_n < 3) begin err_cnt++; $display("[TB] FAIL mid_wait: got %0d words, expected at least 3", val_n); end
    sys_rst_n = 1'b0;
    exp_q.delete();
    #1;
    vec_cnt++; if (rd_sdram_cmd !== C_NOP || rd_sdram_addr !== 12'hFFF || rd_sdram_bank !== 2'b11) begin err_cnt++; $display("[TB] FAIL mid_rst_bus: got %h %h %h, expected 7 fff 3", rd_sdram_cmd, rd_sdram_addr, rd_sdram_bank); end
    vec_cnt++; if ({rd_ack, rd_busy, rd_done, rd_data_valid} !== 4'b0 || rd_data_out !== '0) begin err_cnt++; $display("[TB] FAIL mid_rst_flags: got %b data %h, expected 0000 data 0", {rd_ack, rd_busy, rd_done, rd_data_valid}, rd_data_out); end
    step();
    sys_rst_n = 1'b1;
    step();
    clear_log();
    issue({2'd2, 12'h123, 9'd100}, 10'd5);
    wait_done(100);
    vec_cnt++; if (val_n != 5 || done_n != 1 || act_n != 1) begin err_cnt++; $display("[TB] FAIL post_rst: got words %0d done %0d act %0d, expected 5 1 1", val_n, done_n, act_n); end
  endtask

  task automatic check_drained(input string tag);
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("[TB] FAIL %s_drain: got %0d words outstanding, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic_timing();    check_drained("basic");
    test_page_cross();      check_drained("page");
    test_row_bank_carry();  check_drained("carry");
    test_full_page();       check_drained("full");
    test_zero_len();        check_drained("zero");
    test_no_init();         check_drained("noinit");
    test_back_to_back();    check_drained("busy");
    test_reset_mid_burst(); check_drained("reset");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sdram_rd_burst_ctrl.md
Name: sdram_rd_burst_ctrl

Overview:
Parametrised SDRAM read-burst engine, the successor to the fixed full-page read module. It sits between the SDRAM arbiter and the command/DQ mux. It accepts one read request (start address plus length) and issues ACTIVE / READ / BURST_TERMINATE / PRECHARGE sequences. Reads that cross a page (row) boundary are split automatically into per-row segments. Captured data is returned with a cycle-exact valid strobe.

Parameters:
DQ_W, 16, SDRAM data width
COL_W, 9, column address bits (page = 2^COL_W words)
ROW_W, 12, row address bits; also width of the SDRAM address bus
BANK_W, 2, bank address bits
LEN_W, 10, request length width (1 .. 2^LEN_W-1 words)
CL, 3, CAS latency in cycles (2 or 3)
TRCD, 3, ACTIVE-to-READ spacing in cycles (>=1)
TRP, 2, PRECHARGE-to-next-command spacing in cycles (>=1)

Ports:
sys_clk  in  1  single clock
sys_rst_n  in  1  asynchronous, active-low reset
init_end  in  1  SDRAM init complete; requests are ignored while low
rd_req  in  1  arbiter grant/request; held high until rd_ack
rd_addr  in  BANK_W+ROW_W+COL_W  {bank,row,col} start address
rd_len  in  LEN_W  word count
rd_sdram_data  in  DQ_W  SDRAM DQ input
rd_ack  out  1  one-cycle pulse: request accepted, rd_addr/rd_len latched
rd_busy  out  1  high from the ack cycle through the rd_done cycle
rd_done  out  1  one-cycle pulse: all words returned, banks precharged
rd_data_valid  out  1  rd_data_out holds a valid word
rd_data_out  out  DQ_W  read word, in address order
rd_sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n}, macros from defines.v
rd_sdram_addr  out  ROW_W  SDRAM address bus
rd_sdram_bank  out  BANK_W  SDRAM bank bus

Behaviour:
- Reset values (async, immediate, also mid-operation): cmd NO_OPERATION; addr all ones; bank all ones; rd_ack, rd_busy, rd_done, rd_data_valid = 0; rd_data_out = 0. FSM returns to IDLE. In-flight data is discarded.
- All outputs are registered. "Cycle X" means the cycle in which a value is present on the outputs.
- FSM states: IDLE, ACT, TRCD_W, RD, BURST, DRAIN, PRE, TRP_W, DONE.
- IDLE: when rd_req=1 and init_end=1 at a clock edge, the block latches addr/len. rd_ack=1 and rd_busy=1 in the next cycle (cycle A).
- rd_len=0: the block acks, pulses rd_done in cycle A+1, and issues no commands.
- Otherwise ACTIVE is on the bus in cycle A: addr=row, bank=bank.
- Segment length seg = min(remaining, 2^COL_W - col).
- NOP for TRCD-1 cycles, then READ in cycle R=A+TRCD: addr = column zero-extended, A10=0; bank = current bank.
- BURST_TERMINATE in cycle R+seg; NOP in all other cycles.
- The DQ word k is sampled at the end of cycle R+CL+k. rd_data_valid is high in cycles R+CL+1 .. R+CL+seg, with no gaps inside a segment.
- PRECHARGE in cycle P=R+CL+seg: addr all ones (A10=1, all banks), bank = current bank.
- NOP for TRP-1 cycles. In cycle P+TRP:
  - if remaining>0: ACTIVE for row+1 at column 0. Row overflow carries into bank; bank overflow wraps to address 0.
  - else rd_done=1 and rd_busy=1 (DONE); rd_busy falls the next cycle. A new request is accepted from the edge ending the DONE cycle onward.
- Idle command cycles drive addr/bank all ones.
- rd_req while busy is ignored (no ack). init_end dropping mid-operation does not abort the request.
- Words returned always equal the latched rd_len, in ascending address order across segments.

Test Plan:
1. CL=3, TRCD=3, TRP=2; req at bank 0 / row 5 / col 0, len 4, with A=1 -> ACTIVE@1 row 5, READ@4 col 0, BST@8, valid@8..11 carrying DQ words sampled @7..10, PRE@11, rd_done@13, rd_busy 1..13.
2. Page cross: col 510, len 4 -> READ col 510 seg 2, PRE, ACTIVE row+1, READ col 0 seg 2; 4 valids in order; 2 ACTIVE, 2 PRE, exactly one rd_done.
3. Row/bank carry: bank 0, row 0xFFF, col 511, len 2 -> second segment ACTIVE on bank 1 row 0; address 0x7FFFFF wraps to bank 0 row 0.
4. Full page: col 0, len 512 -> 512 consecutive valids, BST at R+512, a single segment.
5. Edge cases: rd_len=0 -> ack then done next cycle, cmd stays NOP. req with init_end=0 -> no ack. req during busy -> ignored.
6. sys_rst_n low for 1 cycle mid-BURST -> outputs at reset values immediately; the next request completes normally.
